// File: rtl/inverse_clarke_pkg.sv
// inverse_clarke_pkg: shared constants and fixed-point helpers for the inverse Clarke pipeline
package inverse_clarke_pkg;

    localparam int MAXW = 128;

    function automatic int sqrt3_q(input int q);
        longint unsigned n, r, t;
        n = 64'd3 << (2 * q);
        r = 0;
        for (int i = 31; i >= 0; i--) begin
            t = r | (64'd1 << i);
            if (t * t <= n) r = t;
        end
        return int'(r);
    endfunction

    function automatic logic signed [MAXW-1:0] sat_clamp(
        input  logic signed [MAXW-1:0] v,
        input  int                     w,
        output logic                   hit
    );
        logic signed [MAXW-1:0] hi, lo;
        hi  = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo  = -hi - 128'sd1;
        hit = (v > hi) || (v < lo);
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// elastic_stage: valid/ready pipeline register that advances when empty or drained
module elastic_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);
    assign up_ready = !dn_valid || dn_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) dn_data <= up_data;
        end
    end
endmodule

// File: rtl/inverse_clarke_pipe.sv
// inverse_clarke_pipe: two-stage elastic inverse Clarke transform (alpha/beta -> a/b/c)
module inverse_clarke_pipe
    import inverse_clarke_pkg::*;
#(
    parameter int D_WIDTH  = 32,
    parameter int Q_BITS   = 10,
    parameter int CH_BITS  = 2,
    parameter int SATURATE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CH_BITS-1:0]        in_ch,
    input  logic signed [D_WIDTH-1:0] alpha,
    input  logic signed [D_WIDTH-1:0] beta,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CH_BITS-1:0]        out_ch,
    output logic signed [D_WIDTH-1:0] a,
    output logic signed [D_WIDTH-1:0] b,
    output logic signed [D_WIDTH-1:0] c,
    output logic                      sat
);
    localparam int BW = D_WIDTH + Q_BITS + 2;
    localparam int SW = D_WIDTH + Q_BITS + 3;
    localparam int K  = sqrt3_q(Q_BITS);
    localparam logic signed [BW-1:0] KS = BW'(K);

    typedef struct packed {
        logic signed [D_WIDTH-1:0] alpha;
        logic signed [BW-1:0]      bs;
        logic [CH_BITS-1:0]        ch;
    } s1_t;

    typedef struct packed {
        logic signed [D_WIDTH-1:0] a;
        logic signed [D_WIDTH-1:0] b;
        logic signed [D_WIDTH-1:0] c;
        logic                      sat;
        logic [CH_BITS-1:0]        ch;
    } s2_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    logic s1_valid, s2_ready, bhit, chit;
    logic signed [BW-1:0] prod;
    logic signed [SW-1:0] bsum, csum;

    assign prod = BW'(beta) * KS;
    // halving after the full-width sum keeps the floor exact for odd sums
    assign bsum = (SW'(s1_q.bs) - SW'(s1_q.alpha)) >>> 1;
    assign csum = (-SW'(s1_q.alpha) - SW'(s1_q.bs)) >>> 1;

    always_comb begin
        bhit     = 1'b0;
        chit     = 1'b0;
        s1_d     = '{alpha: alpha, bs: prod >>> Q_BITS, ch: in_ch};
        s2_d.a   = s1_q.alpha;
        s2_d.b   = SATURATE != 0 ? D_WIDTH'(sat_clamp(MAXW'(bsum), D_WIDTH, bhit)) : D_WIDTH'(bsum);
        s2_d.c   = SATURATE != 0 ? D_WIDTH'(sat_clamp(MAXW'(csum), D_WIDTH, chit)) : D_WIDTH'(csum);
        s2_d.sat = SATURATE != 0 && (bhit || chit);
        s2_d.ch  = s1_q.ch;
    end

    elastic_stage #(.W($bits(s1_t))) u_s1 (
        .clk      (clk),
        .rst      (rst),
        .up_valid (in_valid),
        .up_ready (in_ready),
        .up_data  (s1_d),
        .dn_valid (s1_valid),
        .dn_ready (s2_ready),
        .dn_data  (s1_q)
    );

    elastic_stage #(.W($bits(s2_t))) u_s2 (
        .clk      (clk),
        .rst      (rst),
        .up_valid (s1_valid),
        .up_ready (s2_ready),
        .up_data  (s2_d),
        .dn_valid (out_valid),
        .dn_ready (out_ready),
        .dn_data  (s2_q)
    );

    assign a      = s2_q.a;
    assign b      = s2_q.b;
    assign c      = s2_q.c;
    assign sat    = s2_q.sat;
    assign out_ch = s2_q.ch;
endmodule

// File: tb/tb_inverse_clarke_pipe.sv
// tb_inverse_clarke_pipe: randomized scoreboard bench over 32-bit saturating and 16-bit saturating/wrapping instances
module tb_inverse_clarke_pipe;
    localparam longint K  = 1773;
    localparam int     QB = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [1:0] in_ch = '0;
    logic [31:0] alpha = '0, beta = '0;

    logic in_ready32, out_valid32, sat32;
    logic [1:0] ch32;
    logic [31:0] a32, b32, c32;
    logic in_ready16s, out_valid16s, sat16s;
    logic [1:0] ch16s;
    logic [15:0] a16s, b16s, c16s;
    logic in_ready16w, out_valid16w, sat16w;
    logic [1:0] ch16w;
    logic [15:0] a16w, b16w, c16w;

    always #5 clk = ~clk;

    inverse_clarke_pipe u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .in_ch(in_ch),
        .alpha(alpha), .beta(beta), .out_valid(out_valid32), .out_ready(out_ready),
        .out_ch(ch32), .a(a32), .b(b32), .c(c32), .sat(sat32)
    );

    inverse_clarke_pipe #(.D_WIDTH(16), .SATURATE(1)) u16s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16s), .in_ch(in_ch),
        .alpha(alpha[15:0]), .beta(beta[15:0]), .out_valid(out_valid16s), .out_ready(out_ready),
        .out_ch(ch16s), .a(a16s), .b(b16s), .c(c16s), .sat(sat16s)
    );

    inverse_clarke_pipe #(.D_WIDTH(16), .SATURATE(0)) u16w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16w), .in_ch(in_ch),
        .alpha(alpha[15:0]), .beta(beta[15:0]), .out_valid(out_valid16w), .out_ready(out_ready),
        .out_ch(ch16w), .a(a16w), .b(b16w), .c(c16w), .sat(sat16w)
    );

    typedef struct {
        logic [31:0] a, b, c;
        logic        sat;
        logic [15:0] a16, sb, sc;
        logic        ssat;
        logic [15:0] wb, wc;
        logic [1:0]  ch;
    } exp_t;

    exp_t q[$];
    int tests = 0, fails = 0;
    int inflight = 0, npop = 0, n16s = 0, n16w = 0, rmode = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint clampv(input longint v, input int w);
        longint lim = longint'(1) << (w - 1);
        return v > lim - 1 ? lim - 1 : v < -lim ? -lim : v;
    endfunction

    // floor((-alpha +/- floor(beta*K/2^Q)) / 2) in plain 64-bit arithmetic
    function automatic exp_t model(input logic [31:0] al, input logic [31:0] be, input logic [1:0] ch);
        exp_t e;
        longint x, y, bs, bv, cv;
        logic [15:0] al16, be16;
        x  = longint'($signed(al));
        y  = longint'($signed(be));
        bs = (y * K) >>> QB;
        bv = (bs - x) >>> 1;
        cv = (-x - bs) >>> 1;
        e.a   = al;
        e.b   = 32'(clampv(bv, 32));
        e.c   = 32'(clampv(cv, 32));
        e.sat = (bv != clampv(bv, 32)) || (cv != clampv(cv, 32));
        al16 = al[15:0];
        be16 = be[15:0];
        x  = longint'($signed(al16));
        y  = longint'($signed(be16));
        bs = (y * K) >>> QB;
        bv = (bs - x) >>> 1;
        cv = (-x - bs) >>> 1;
        e.a16  = al16;
        e.sb   = 16'(clampv(bv, 16));
        e.sc   = 16'(clampv(cv, 16));
        e.ssat = (bv != clampv(bv, 16)) || (cv != clampv(cv, 16));
        e.wb   = 16'(bv);
        e.wc   = 16'(cv);
        e.ch   = ch;
        return e;
    endfunction

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 6))
            0: return 32'h7fffffff;
            1: return 32'h80000000;
            2: return 32'h00007fff;
            3: return 32'hffff8000;
            4: return 32'($urandom_range(0, 4095)) - 32'd2048;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 3 == 0) :
                        rmode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // scoreboard monitor
    logic stall = 1'b0;
    logic [98:0] p32;
    logic [50:0] p16s, p16w;
    always @(negedge clk) begin
        logic [98:0] o32;
        logic [50:0] o16s, o16w;
        logic exp_rdy;
        exp_t e;
        o32  = {ch32, a32, b32, c32, sat32};
        o16s = {ch16s, a16s, b16s, c16s, sat16s};
        o16w = {ch16w, a16w, b16w, c16w, sat16w};
        if (rst) begin
            inflight = 0;
            stall = 1'b0;
        end else begin
            exp_rdy = !(inflight == 2 && !out_ready);
            chk("in_ready32", in_ready32, exp_rdy);
            chk("in_ready16s", in_ready16s, exp_rdy);
            chk("in_ready16w", in_ready16w, exp_rdy);
            if (stall) begin
                chk("stall_valid32", out_valid32, 1);
                chk("stall_hold32", o32 == p32, 1);
                chk("stall_hold16s", o16s == p16s, 1);
                chk("stall_hold16w", o16w == p16w, 1);
            end
            if (out_valid32 && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    npop++;
                    chk("a32", a32, e.a);
                    chk("b32", b32, e.b);
                    chk("c32", c32, e.c);
                    chk("sat32", sat32, e.sat);
                    chk("ch32", ch32, e.ch);
                    chk("a16s", a16s, e.a16);
                    chk("b16s", b16s, e.sb);
                    chk("c16s", c16s, e.sc);
                    chk("sat16s", sat16s, e.ssat);
                    chk("ch16s", ch16s, e.ch);
                    chk("a16w", a16w, e.a16);
                    chk("b16w", b16w, e.wb);
                    chk("c16w", c16w, e.wc);
                    chk("sat16w", sat16w, 0);
                    chk("ch16w", ch16w, e.ch);
                end
            end
            if (in_valid && in_ready32) inflight++;
            if (out_valid32 && out_ready) inflight--;
            if (out_valid16s && out_ready) n16s++;
            if (out_valid16w && out_ready) n16w++;
            stall = out_valid32 && !out_ready;
            p32  = o32;
            p16s = o16s;
            p16w = o16w;
        end
    end

    task automatic send(input logic [31:0] al, input logic [31:0] be, input logic [1:0] ch);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        alpha = al;
        beta = be;
        in_ch = ch;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready32) begin
                q.push_back(model(al, be, ch));
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("send_timeout", 1, 0);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        idle();
        for (i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic latency_check(input string nm);
        int n;
        idle();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (out_valid32) break;
        end
        chk(nm, n, 2);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_valid"}, {out_valid32, out_valid16s, out_valid16w}, 0);
        chk({nm, "_data32"}, {a32, b32, c32, sat32, ch32}, 0);
        chk({nm, "_data16"}, {a16s, b16s, c16s, sat16s, ch16s, a16w, b16w, c16w, sat16w, ch16w}, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        chk("reset_in_ready", {in_ready32, in_ready16s, in_ready16w}, 3'b111);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send(32'd1024, 32'd0, 2'd0);
        latency_check("latency");
        send(32'd1024, 32'd1024, 2'd1);
        send(32'hffff8000, 32'd32767, 2'd2);
        send(32'h80000000, 32'h7fffffff, 2'd3);
        drain();

        rmode = 1;
        for (int i = 0; i < 8; i++) send(rval(), rval(), 2'(i % 4));
        drain();

        rmode = 0;
        for (int i = 0; i < 30; i++) send(rval(), rval(), 2'($urandom_range(0, 3)));
        drain();

        rmode = 2;
        for (int i = 0; i < 200; i++) begin
            send(rval(), rval(), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle();
        end
        drain();

        rmode = 3;
        send(rval(), rval(), 2'd1);
        send(rval(), rval(), 2'd2);
        idle();
        #1;
        chk("full_before_reset", out_valid32, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        rmode = 0;
        send(32'd1024, 32'd1024, 2'd3);
        latency_check("latency_after_reset");
        drain();

        chk("queue_empty", q.size(), 0);
        chk("count16s", n16s, npop);
        chk("count16w", n16w, npop);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
